// File: rtl/fir_pkg.sv
// Shared sizing and saturation helpers for the FIR accumulate/saturate stages.
package fir_pkg;

  localparam int DATA_W_DEF = 24;

  // Accumulator must hold NUM_TAPS worst-case products plus a sign guard bit.
  function automatic int acc_width(input int data_w, input int num_taps);
    return data_w + $clog2(num_taps) + 1;
  endfunction

  function automatic longint sat_max(input int data_w);
    return (longint'(1) <<< (data_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int data_w);
    return -(longint'(1) <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/sat_trunc.sv
// Combinational signed saturate-and-truncate from IN_W bits down to OUT_W bits.
module sat_trunc
  import fir_pkg::*;
#(
  parameter int IN_W  = 27,
  parameter int OUT_W = 24
) (
  input  logic [IN_W-1:0]  val_i,
  output logic [OUT_W-1:0] val_o,
  output logic             ovf_o
);

  localparam logic [IN_W-1:0]  MAX_IN  = IN_W'(sat_max(OUT_W));
  localparam logic [IN_W-1:0]  MIN_IN  = IN_W'(sat_min(OUT_W));
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(sat_max(OUT_W));
  localparam logic [OUT_W-1:0] MIN_OUT = OUT_W'(sat_min(OUT_W));

  always_comb begin
    val_o = val_i[OUT_W-1:0];
    ovf_o = 1'b0;
    if ($signed(val_i) > $signed(MAX_IN)) begin
      val_o = MAX_OUT;
      ovf_o = 1'b1;
    end else if ($signed(val_i) < $signed(MIN_IN)) begin
      val_o = MIN_OUT;
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/fir_accum.sv
// Sums NUM_TAPS consecutive signed products into one saturated output sample,
// with a ready/valid registered output that holds under backpressure.
module fir_accum
  import fir_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_TAPS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_ready,
  output logic              o_sat
);

  localparam int ACC_W = acc_width(DATA_W, NUM_TAPS);
  localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sat_q, sat_d;
  logic              valid_q, valid_d;

  logic              last_tap;
  logic              accept;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] sum_sat;
  logic              sum_ovf;

  assign last_tap = (cnt_q == LAST_TAP);
  // Only the final tap needs the output register free; earlier taps keep flowing.
  assign o_ready  = !last_tap || !valid_q || i_ready;
  assign accept   = i_valid && o_ready;
  assign sum      = ((cnt_q == '0) ? '0 : acc_q)
                  + {{(ACC_W-DATA_W){i_data[DATA_W-1]}}, i_data};

  sat_trunc #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_sat (
    .val_i (sum),
    .val_o (sum_sat),
    .ovf_o (sum_ovf)
  );

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    if (valid_q && i_ready) valid_d = 1'b0;
    if (accept) begin
      if (last_tap) begin
        data_d  = sum_sat;
        sat_d   = sum_ovf;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_sat   = sat_q;
  assign o_valid = valid_q;

endmodule
